// File: rtl/stage_sequencer.sv
// stage_sequencer: walks the four Saturn V burns, loads per-burn core parameters and guards each burn with a watchdog
module stage_sequencer #(
  parameter int N              = 64,
  parameter int CYCLES_PER_SEC = 50,
  parameter int SEP_CYCLES     = 4,
  parameter int WDOG_MARGIN    = 100,
  parameter int ISP_1          = 263,
  parameter int ISP_2          = 421,
  parameter int ISP_3          = 421,
  parameter int ISP_4          = 421,
  parameter int PROP_1         = 2077000,
  parameter int PROP_2         = 456100,
  parameter int PROP_3         = 39136,
  parameter int PROP_4         = 83864,
  parameter int BURN_1         = 168,
  parameter int BURN_2         = 360,
  parameter int BURN_3         = 165,
  parameter int BURN_4         = 335,
  parameter int DRY_1          = 137000,
  parameter int DRY_2          = 40100,
  parameter int DRY_3          = 15200,
  parameter int PAYLOAD        = 27003
) (
  input  logic         CLK,
  input  logic         RESETB,
  input  logic         LAUNCH,
  input  logic         IGN_END,
  input  logic         RESTART_GO,
  input  logic         ABORT,
  output logic         CORE_RESETB,
  output logic [2:0]   STAGE,
  output logic [N-1:0] ISP,
  output logic [N-1:0] INIT_WEIGHT,
  output logic [N-1:0] PROP_WEIGHT,
  output logic [N-1:0] BURN_TIME,
  output logic         BURNING,
  output logic         SEP_STROBE,
  output logic         DONE,
  output logic         FAULT
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_BURN, S_SEP, S_COAST, S_DONE, S_FAULT} state_t;
  // Vehicle mass at each burn start, built from the top down so burn 4 keeps the S-IVB dry mass
  localparam logic [N-1:0] W4 = N'(PROP_4) + N'(DRY_3) + N'(PAYLOAD);
  localparam logic [N-1:0] W3 = W4 + N'(PROP_3);
  localparam logic [N-1:0] W2 = W3 + N'(PROP_2) + N'(DRY_2);
  localparam logic [N-1:0] W1 = W2 + N'(PROP_1) + N'(DRY_1);
  localparam logic [31:0] LIM_1 = 32'(BURN_1 * CYCLES_PER_SEC + WDOG_MARGIN);
  localparam logic [31:0] LIM_2 = 32'(BURN_2 * CYCLES_PER_SEC + WDOG_MARGIN);
  localparam logic [31:0] LIM_3 = 32'(BURN_3 * CYCLES_PER_SEC + WDOG_MARGIN);
  localparam logic [31:0] LIM_4 = 32'(BURN_4 * CYCLES_PER_SEC + WDOG_MARGIN);
  state_t state, state_nxt;
  logic [31:0] cnt, lim;
  logic [2:0] stage_nxt;
  logic expire;
  logic [N-1:0] isp_sel, w_sel, prop_sel, burn_sel;
  // cnt doubles as watchdog in BURN and separation timer in SEPARATE; it clears on every state change
  always_ff @(posedge CLK or negedge RESETB)
    if (!RESETB) begin
      state       <= S_IDLE;
      cnt         <= '0;
      STAGE       <= '0;
      ISP         <= '0;
      INIT_WEIGHT <= '0;
      PROP_WEIGHT <= '0;
      BURN_TIME   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? '0 : cnt + 32'd1;
      if (state_nxt == S_LOAD && state != S_LOAD) begin
        STAGE       <= stage_nxt;
        ISP         <= isp_sel;
        INIT_WEIGHT <= w_sel;
        PROP_WEIGHT <= prop_sel;
        BURN_TIME   <= burn_sel;
      end
    end
  always_comb begin
    stage_nxt = STAGE + 3'd1;
    isp_sel   = stage_nxt == 3'd1 ? N'(ISP_1)  : stage_nxt == 3'd2 ? N'(ISP_2)  : stage_nxt == 3'd3 ? N'(ISP_3)  : N'(ISP_4);
    w_sel     = stage_nxt == 3'd1 ? W1         : stage_nxt == 3'd2 ? W2         : stage_nxt == 3'd3 ? W3         : W4;
    prop_sel  = stage_nxt == 3'd1 ? N'(PROP_1) : stage_nxt == 3'd2 ? N'(PROP_2) : stage_nxt == 3'd3 ? N'(PROP_3) : N'(PROP_4);
    burn_sel  = stage_nxt == 3'd1 ? N'(BURN_1) : stage_nxt == 3'd2 ? N'(BURN_2) : stage_nxt == 3'd3 ? N'(BURN_3) : N'(BURN_4);
    lim       = STAGE == 3'd1 ? LIM_1 : STAGE == 3'd2 ? LIM_2 : STAGE == 3'd3 ? LIM_3 : LIM_4;
    expire    = (cnt + 32'd1) >= lim;
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = LAUNCH ? S_LOAD : S_IDLE;
      S_LOAD:  state_nxt = ABORT ? S_FAULT : S_BURN;
      S_BURN:  state_nxt = ABORT ? S_FAULT :
                           IGN_END ? (STAGE < 3'd3 ? S_SEP : STAGE == 3'd3 ? S_COAST : S_DONE) :
                           expire ? S_FAULT : S_BURN;
      S_SEP:   state_nxt = ABORT ? S_FAULT : (cnt == 32'(SEP_CYCLES - 1)) ? S_LOAD : S_SEP;
      S_COAST: state_nxt = ABORT ? S_FAULT : RESTART_GO ? S_LOAD : S_COAST;
      default: state_nxt = state;
    endcase
  end
  always_comb begin
    CORE_RESETB = state == S_BURN;
    BURNING     = state == S_BURN;
    SEP_STROBE  = state == S_SEP && cnt == '0;
    DONE        = state == S_DONE;
    FAULT       = state == S_FAULT;
  end
endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: directed walk through all burns, watchdog expiry, reset and abort with a queued scoreboard
module tb_stage_sequencer;
  logic CLK = 0, RESETB = 0, LAUNCH = 0, IGN_END = 0, RESTART_GO = 0, ABORT = 0;
  logic CORE_RESETB, BURNING, SEP_STROBE, DONE, FAULT;
  logic [2:0] STAGE;
  logic [63:0] ISP, INIT_WEIGHT, PROP_WEIGHT, BURN_TIME;
  int n_cmp = 0, n_bad = 0;
  logic [63:0] exp_q[$];
  string tag_q[$];
  stage_sequencer dut (
    .CLK(CLK), .RESETB(RESETB), .LAUNCH(LAUNCH), .IGN_END(IGN_END),
    .RESTART_GO(RESTART_GO), .ABORT(ABORT), .CORE_RESETB(CORE_RESETB),
    .STAGE(STAGE), .ISP(ISP), .INIT_WEIGHT(INIT_WEIGHT), .PROP_WEIGHT(PROP_WEIGHT),
    .BURN_TIME(BURN_TIME), .BURNING(BURNING), .SEP_STROBE(SEP_STROBE),
    .DONE(DONE), .FAULT(FAULT)
  );
  always #5 CLK = ~CLK;
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask
  task automatic want(input string t, input logic [63:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask
  task automatic chk(input logic [63:0] obs);
    string t;
    logic [63:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard_empty: got %0d expected an entry", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_bad++;
        $error("FAIL %s: got %0d expected %0d", t, obs, e);
      end
    end
  endtask
  task automatic do_reset();
    RESETB = 0;
    tick(2);
    RESETB = 1;
    tick(1);
  endtask
  task automatic launch();
    LAUNCH = 1;
    tick(1);
    LAUNCH = 0;
  endtask
  task automatic end_burn(input int cycles);
    tick(cycles - 1);
    IGN_END = 1;
    tick(1);
    IGN_END = 0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    do_reset();
    tick(2);
    want("idle_stage", 0); want("idle_core", 0); want("idle_isp", 0); want("idle_done", 0); want("idle_fault", 0);
    chk(STAGE); chk(CORE_RESETB); chk(ISP); chk(DONE); chk(FAULT);
    want("b1_stage", 1); want("b1_isp", 263); want("b1_w", 2875403); want("b1_prop", 2077000);
    want("b1_burn", 168); want("b1_core_load", 0);
    launch();
    chk(STAGE); chk(ISP); chk(INIT_WEIGHT); chk(PROP_WEIGHT); chk(BURN_TIME); chk(CORE_RESETB);
    want("b1_core_burn", 1); want("b1_burning", 1);
    tick(1);
    chk(CORE_RESETB); chk(BURNING);
    want("sep1_strobe", 1); want("sep1_core", 0);
    end_burn(100);
    chk(SEP_STROBE); chk(CORE_RESETB);
    want("sep1_strobe_off", 0); want("sep1_core_mid", 0);
    tick(1);
    chk(SEP_STROBE); chk(CORE_RESETB);
    want("b2_stage", 2); want("b2_w", 661403); want("b2_burn", 360); want("b2_core_load", 0);
    tick(3);
    chk(STAGE); chk(INIT_WEIGHT); chk(BURN_TIME); chk(CORE_RESETB);
    want("b2_core_burn", 1);
    tick(1);
    chk(CORE_RESETB);
    end_burn(10);
    want("b3_stage", 3); want("b3_isp", 421); want("b3_w", 165203); want("b3_prop", 39136);
    tick(4);
    chk(STAGE); chk(ISP); chk(INIT_WEIGHT); chk(PROP_WEIGHT);
    tick(1);
    want("coast_stage", 3); want("coast_strobe", 0); want("coast_core", 0); want("coast_burning", 0);
    end_burn(20);
    chk(STAGE); chk(SEP_STROBE); chk(CORE_RESETB); chk(BURNING);
    want("coast_hold", 3);
    tick(5);
    chk(STAGE);
    want("b4_stage", 4); want("b4_w", 126067); want("b4_burn", 335); want("b4_prop", 83864);
    RESTART_GO = 1;
    tick(1);
    RESTART_GO = 0;
    chk(STAGE); chk(INIT_WEIGHT); chk(BURN_TIME); chk(PROP_WEIGHT);
    tick(1);
    want("done_set", 1); want("done_core", 0);
    end_burn(30);
    chk(DONE); chk(CORE_RESETB);
    want("done_sticky", 1); want("done_stage", 4); want("done_fault", 0);
    tick(3);
    launch();
    tick(2);
    chk(DONE); chk(STAGE); chk(FAULT);
    do_reset();
    launch();
    tick(1);
    want("wd_pre_fault", 0); want("wd_pre_burning", 1);
    tick(8499);
    chk(FAULT); chk(BURNING);
    want("wd_fault", 1); want("wd_core", 0);
    tick(1);
    chk(FAULT); chk(CORE_RESETB);
    want("wd_launch_fault", 1); want("wd_launch_stage", 1);
    launch();
    tick(1);
    chk(FAULT); chk(STAGE);
    do_reset();
    launch();
    tick(1);
    want("wd_edge_strobe", 1); want("wd_edge_fault", 0);
    end_burn(8500);
    chk(SEP_STROBE); chk(FAULT);
    want("rst_b2_stage", 2);
    tick(4);
    chk(STAGE);
    tick(6);
    want("rst_stage", 0); want("rst_core", 0); want("rst_fault", 0); want("rst_isp", 0);
    #2 RESETB = 0;
    #1;
    chk(STAGE); chk(CORE_RESETB); chk(FAULT); chk(ISP);
    RESETB = 1;
    tick(1);
    want("relaunch_stage", 1); want("relaunch_isp", 263);
    launch();
    chk(STAGE); chk(ISP);
    tick(1);
    want("abort_fault", 1); want("abort_strobe", 0); want("abort_stage", 1);
    ABORT = 1;
    IGN_END = 1;
    tick(1);
    ABORT = 0;
    IGN_END = 0;
    chk(FAULT); chk(SEP_STROBE); chk(STAGE);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
